ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_keyboard_rx.sv | 145 ++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser,
// one-cycle result pulses for the downstream scan-code translator.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt, filt_prev, fall_q, data_q;
    logic [FW-1:0]   fcnt;
    logic [7:0]      shift_reg, shift_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic            par_bit, par_n;
    logic [WW-1:0]   wdog, wdog_n;
    logic [7:0]      code_n;
    logic            ready_n, perr_n, ferr_n, terr_n, timeout;

    // Conditioning: sync both pins, debounce the clock, register the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            fcnt      <= '0;
            fall_q    <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt;
            fall_q    <= filt_prev & ~filt;
            data_q    <= dat_s2;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= ~filt;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign timeout = (state != IDLE) && (wdog == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n  = state;
        shift_n  = shift_reg;
        bitcnt_n = bitcnt;
        par_n    = par_bit;
        code_n   = scan_code;
        ready_n  = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;
        terr_n   = 1'b0;
        wdog_n   = (state == IDLE || fall_q) ? '0 : wdog + 1'b1;
        // Watchdog beats a coincident edge.
        if (timeout) begin
            terr_n  = 1'b1;
            state_n = IDLE;
            wdog_n  = '0;
        end else if (fall_q) begin
            case (state)
                IDLE: begin
                    if (!data_q) begin
                        state_n  = DATA;
                        bitcnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shift_n  = {data_q, shift_reg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = data_q;
                    state_n = STOP;
                end
                STOP: begin
                    if (!data_q) begin
                        ferr_n = 1'b1;
                    end else if (^{shift_reg, par_bit} == 1'b0) begin
                        perr_n = 1'b1;
                    end else begin
                        code_n  = shift_reg;
                        ready_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= 8'h00;
            bitcnt      <= 3'd0;
            par_bit     <= 1'b0;
            wdog        <= '0;
            scan_code   <= 8'h00;
            scan_ready  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            bitcnt      <= bitcnt_n;
            par_bit     <= par_n;
            wdog        <= wdog_n;
            scan_code   <= code_n;
            scan_ready  <= ready_n;
            parity_err  <= perr_n;
            frame_err   <= ferr_n;
            timeout_err <= terr_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a pulse scoreboard.
// Frames are bit-banged on the pins; expected pulses are queued as they are sent.
module tb_ps2_keyboard_rx;

    localparam int F    = 8;
    localparam int TMO  = 10000;
    localparam int HALF = 20;

    localparam int K_OK  = 0;
    localparam int K_PAR = 1;
    localparam int K_FRM = 2;
    localparam int K_TMO = 3;

    typedef struct {
        int         kind;
        logic [7:0] code;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_ready, parity_err, frame_err, timeout_err, busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ps2_keyboard_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scan_code(scan_code),
        .scan_ready(scan_ready),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; when last is set the expected pulse is queued with the
    // cycle it must appear on.
    task automatic ps2_bit(input logic b, input logic last, input exp_t e);
        exp_t q;
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (last) begin
            q = e;
            q.cyc = cyc + 1 + F + 3;
            sb.push_back(q);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par,
                              input logic stop);
        exp_t e;
        e.code = code;
        e.cyc  = 0;
        if (!stop) e.kind = K_FRM;
        else if (^{code, par} == 1'b0) e.kind = K_PAR;
        else e.kind = K_OK;
        ps2_bit(1'b0, 1'b0, e);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0, e);
        ps2_bit(par, 1'b0, e);
        ps2_bit(stop, 1'b1, e);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic partial(input logic [7:0] code, input int nbits);
        exp_t e;
        e.kind = K_OK;
        e.code = code;
        e.cyc  = 0;
        ps2_bit(1'b0, 1'b0, e);
        for (int i = 0; i < nbits; i++) ps2_bit(code[i], 1'b0, e);
    endtask

    // Scoreboard: every pulse must match the head of the queue.
    always @(negedge clk) begin
        int   n;
        int   obs;
        exp_t e;
        if (!reset && (scan_ready | parity_err | frame_err | timeout_err)) begin
            n = int'(scan_ready) + int'(parity_err) + int'(frame_err)
                + int'(timeout_err);
            chk("one_pulse", n, 1);
            obs = scan_ready ? K_OK : parity_err ? K_PAR :
                  frame_err ? K_FRM : K_TMO;
            chk("pulse_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pulse_kind", obs, e.kind);
                if (e.kind == K_OK) chk("scan_code", scan_code, e.code);
                if (e.cyc != 0) chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        exp_t e;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_code", scan_code, 8'h00);
        chk("rst_pulses", {scan_ready, parity_err, frame_err, timeout_err}, 0);
        chk("rst_busy", busy, 0);

        send_frame(8'h1C, 1'b0, 1'b1);
        chk("good_code", scan_code, 8'h1C);
        chk("good_idle", busy, 0);

        send_frame(8'hF0, 1'b1, 1'b1);
        chk("break_code", scan_code, 8'hF0);
        chk("break_low", scan_ready, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("break_next", scan_code, 8'h1C);

        send_frame(8'h29, 1'b1, 1'b1);
        chk("perr_hold", scan_code, 8'h1C);
        send_frame(8'h29, 1'b1, 1'b0);
        chk("ferr_hold", scan_code, 8'h1C);

        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (F - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2 * F) begin
            @(negedge clk);
            if (busy !== 1'b0) break;
        end
        chk("glitch_busy", busy, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("glitch_code", scan_code, 8'h29);

        partial(8'h33, 4);
        chk("tmo_busy_mid", busy, 1);
        e.kind = K_TMO;
        e.code = 8'h00;
        e.cyc  = 0;
        sb.push_back(e);
        repeat (TMO + 50) @(negedge clk);
        chk("tmo_busy", busy, 0);
        chk("tmo_code", scan_code, 8'h29);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("tmo_next", scan_code, 8'h5A);

        partial(8'h77, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_code", scan_code, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses",
            {scan_ready, parity_err, frame_err, timeout_err}, 0);
        repeat (3 * F) @(negedge clk);
        send_frame(8'h16, 1'b0, 1'b1);
        chk("mid_rst_next", scan_code, 8'h16);

        repeat (50) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
